seg7_scan_decoder: RTL and testbench

- Inverse of the team's binary-to-seven-segment encoder.
- Samples a time-multiplexed seven-segment bus (segment pattern plus one-hot digit select) and recovers each digit's 4-bit value.
- Accepts a digit only after its pattern has been stable for a programmable dwell, and assembles a multi-digit word.
- Used by the microprocessor test harness to read back the display bus as data.

---
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers nibbles from a time-multiplexed seven-segment bus after a stable dwell per digit.
// Optional decimal-point tracking is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  dp_in,
  output logic [DIGITS-1:0]     dp_mask,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     valid_mask,
  output logic                  frame_done,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StBlank, StSettle, StHold} state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [6:0]        seg_q, seg_p;
  logic [DIGITS-1:0] sel_q, sel_p;
  logic [DIGITS-1:0] seen_q;
  logic [DIGITS-1:0] seen_set;
  logic              change;
  logic              one_hot;
  logic              hit;
  logic              blank;
  logic [3:0]        nib;
  logic [2:0]        idx;

`ifdef SEG7_SCAN_DP_EN
  logic dp_q, dp_p;
  assign change = (seg_q != seg_p) || (sel_q != sel_p) || (dp_q != dp_p);
`else
  assign change = (seg_q != seg_p) || (sel_q != sel_p);
`endif

  assign one_hot  = $onehot(sel_q);
  assign blank    = (seg_q == 7'h00);
  // sel_q is one-hot whenever a capture happens, so it doubles as the digit's bit mask
  assign seen_set = seen_q | sel_q;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sel_q[i]) idx = 3'(i);
    end
  end

  always_comb begin
    hit = 1'b1;
    nib = 4'h0;
    case (seg_q)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBlank;
      cnt_q      <= 8'd0;
      seg_q      <= 7'h00;
      seg_p      <= 7'h00;
      sel_q      <= '0;
      sel_p      <= '0;
      seen_q     <= '0;
      value      <= '0;
      valid_mask <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_digit  <= 3'd0;
`ifdef SEG7_SCAN_DP_EN
      dp_q       <= 1'b0;
      dp_p       <= 1'b0;
      dp_mask    <= '0;
`endif
    end else begin
      seg_q      <= seg_in;
      sel_q      <= dig_sel;
      seg_p      <= seg_q;
      sel_p      <= sel_q;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_q       <= dp_in;
      dp_p       <= dp_q;
`endif
      case (state_q)
        StBlank: begin
          if (one_hot) begin
            state_q <= StSettle;
            cnt_q   <= 8'd1;
          end
        end
        StSettle, StHold: begin
          if (change) begin
            state_q <= one_hot ? StSettle : StBlank;
            cnt_q   <= one_hot ? 8'd1 : 8'd0;
          end else if (state_q == StSettle) begin
            if (cnt_q >= SettleMax) begin
              state_q <= StHold;
              for (int i = 0; i < int'(DIGITS); i++) begin
                if (sel_q[i]) begin
                  if (hit) value[4*i +: 4] <= nib;
                  valid_mask[i] <= hit;
`ifdef SEG7_SCAN_DP_EN
                  dp_mask[i]    <= dp_q;
`endif
                end
              end
              if (!hit && !blank) begin
                err       <= 1'b1;
                err_digit <= idx;
              end
              // The frame-completing capture is consumed by this pulse
              if (&seen_set) begin
                frame_done <= 1'b1;
                seen_q     <= '0;
              end else begin
                seen_q     <= seen_set;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= StBlank;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, SETTLE_CYCLES=3) with immediate assertions.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic [3:0]  valid_mask;
  logic        frame_done;
  logic        err;
  logic [2:0]  err_digit;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int err_cnt  = 0;
  bit saw5     = 1'b0;

  seg7_scan_decoder #(
    .DIGITS        (4),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .value      (value),
    .valid_mask (valid_mask),
    .frame_done (frame_done),
    .err        (err),
    .err_digit  (err_digit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    if (err === 1'b1) err_cnt++;
    if (value[7:4] === 4'h5) saw5 = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] pats [4];

  initial begin
    pats    = '{7'h06, 7'h5B, 7'h7D, 7'h71};
    rst_n   = 1'b0;
    seg_in  = 7'h00;
    dig_sel = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(valid_mask), 32'h0);
    check("rst_fd_err", 32'({frame_done, err, err_digit}), 32'h0);
    rst_n = 1'b1;

    // First capture: visible exactly SETTLE_CYCLES+1 edges after the sampling edge
    seg_in  = 7'h4F;
    dig_sel = 4'b0001;
    repeat (4) step();
    check("early_valid", 32'(valid_mask), 32'h0);
    check("early_value", 32'(value), 32'h0);
    step();
    check("cap0_value", 32'(value), 32'h0003);
    check("cap0_valid", 32'(valid_mask), 32'h1);
    check("cap0_err", 32'(err_cnt), 32'h0);

    // Full scan; frame completes on digit 3
    fd_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      seg_in  = pats[d];
      dig_sel = 4'(1 << d);
      if (d < 3) begin
        repeat (5) step();
      end else begin
        repeat (4) step();
        check("fd_before", 32'({frame_done, valid_mask}), 32'h07);
        step();
        check("fd_pulse", 32'(frame_done), 32'h1);
      end
    end
    check("scan_value", 32'(value), 32'hF621);
    check("scan_valid", 32'(valid_mask), 32'hF);
    check("scan_fd_cnt", 32'(fd_cnt), 32'h1);

    // Undecodable pattern on digit 2
    err_cnt = 0;
    seg_in  = 7'h2A;
    dig_sel = 4'b0100;
    repeat (4) step();
    check("err_early", 32'(err), 32'h0);
    step();
    check("err_pulse", 32'({err, err_digit}), 32'hA);
    repeat (5) step();
    check("err_once", 32'(err_cnt), 32'h1);
    check("err_digit_hold", 32'(err_digit), 32'h2);
    check("err_valid", 32'(valid_mask), 32'hB);
    check("err_value", 32'(value), 32'hF621);

    // Two select bits: never captured
    seg_in  = 7'h3F;
    dig_sel = 4'b0110;
    repeat (10) step();
    check("multi_value", 32'(value), 32'hF621);
    check("multi_valid", 32'(valid_mask), 32'hB);
    check("multi_err_fd", 32'({err_cnt[7:0], fd_cnt[7:0]}), 32'h0101);

    // Pattern changes mid-dwell; only the final pattern is captured
    saw5    = 1'b0;
    seg_in  = 7'h6D;
    dig_sel = 4'b0010;
    repeat (2) step();
    seg_in  = 7'h6F;
    repeat (4) step();
    check("toggle_wait", 32'(value), 32'hF621);
    step();
    check("toggle_value", 32'(value), 32'hF691);
    repeat (5) step();
    check("toggle_no5", 32'(saw5), 32'h0);
    check("toggle_valid", 32'(valid_mask), 32'hB);

    // Reset mid-dwell clears everything and restarts the dwell
    fd_cnt  = 0;
    seg_in  = 7'h4F;
    dig_sel = 4'b1000;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_valid", 32'(valid_mask), 32'h0);
    check("mid_rst_err_digit", 32'(err_digit), 32'h0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("post_rst_early", 32'(valid_mask), 32'h0);
    step();
    check("post_rst_value", 32'(value), 32'h3000);
    check("post_rst_valid", 32'(valid_mask), 32'h8);

    // Blank pattern clears valid without error or value change
    err_cnt = 0;
    seg_in  = 7'h00;
    repeat (5) step();
    check("blank_valid", 32'(valid_mask), 32'h0);
    check("blank_value", 32'(value), 32'h3000);
    check("blank_err", 32'(err_cnt), 32'h0);
    check("blank_fd", 32'(fd_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
